// File: rtl/dmem_ctrl_pkg.sv
// Shared types for the data-memory arbiter/controller.
// Build option: MISALIGN_CHECK_EN (see dmem_arbiter_ctrl).
package dmem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } dmemState_t;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_AUX  = 1'b1
    } dmemOwner_t;

endpackage

// File: rtl/dmem_prio_arb.sv
// Fixed-priority core/aux grant with a starvation counter that forces
// aux ahead once it has waited STARVE_MAX consecutive cycles.
module dmem_prio_arb #(
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic core_req,
    input  logic aux_req,
    input  logic arb_en,
    output logic gnt_core,
    output logic gnt_aux
);

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    logic [7:0] starveCnt;
    logic       auxUrgent;

    // Grant decision: urgent aux beats core, otherwise core beats aux.
    always_comb begin
        gnt_core  = 1'b0;
        gnt_aux   = 1'b0;
        auxUrgent = aux_req && (starveCnt == STARVE_LIM);
        if (arb_en) begin
            if (auxUrgent) begin
                gnt_aux = 1'b1;
            end else if (core_req) begin
                gnt_core = 1'b1;
            end else if (aux_req) begin
                gnt_aux = 1'b1;
            end
        end
    end

    // Count consecutive cycles aux waits; clear on its grant or when it is idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starveCnt <= '0;
        end else if (!aux_req || gnt_aux) begin
            starveCnt <= '0;
        end else if (starveCnt != STARVE_LIM) begin
            starveCnt <= starveCnt + 8'd1;
        end
    end

endmodule

// File: rtl/dmem_arbiter_ctrl.sv
// Data-memory sequencer shared by the Memory stage (core) and an aux port.
// req/ready/rvalid handshake toward memory, stall toward the hazard unit.
// Build option: MISALIGN_CHECK_EN adds core_err and rejects misaligned
// core accesses without touching memory.
module dmem_arbiter_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_stall,
    output logic              core_done,
    output logic [DATA_W-1:0] core_rdata,
`ifdef MISALIGN_CHECK_EN
    output logic              core_err,
`endif
    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [DATA_W-1:0] aux_wdata,
    output logic              aux_done,
    output logic [DATA_W-1:0] aux_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    dmemState_t        state, nextState;
    dmemOwner_t        ownerQ;
    logic              weQ;
    logic [ADDR_W-1:0] addrQ;
    logic [DATA_W-1:0] wdataQ;
    logic              coreDoneQ, auxDoneQ;
    logic [DATA_W-1:0] coreRdataQ, auxRdataQ;
    logic              arbEn, gntCore, gntAux;
    logic              opComplete, misalign;

    // The done cycle is spent in IDLE with arbitration held off, so a
    // request still asserted for the finished access is not reissued.
    assign arbEn = (state == IDLE) && !coreDoneQ && !auxDoneQ;

    dmem_prio_arb #(
        .STARVE_MAX(STARVE_MAX)
    ) uArb (
        .clk      (clk),
        .rst      (rst),
        .core_req (core_req),
        .aux_req  (aux_req),
        .arb_en   (arbEn),
        .gnt_core (gntCore),
        .gnt_aux  (gntAux)
    );

    // Next-state and completion decode.
    always_comb begin
        nextState  = state;
        opComplete = 1'b0;
        misalign   = 1'b0;
        unique case (state)
            IDLE: begin
                if (gntCore || gntAux) begin
                    nextState = ISSUE;
                end
`ifdef MISALIGN_CHECK_EN
                if (gntCore && (core_addr[1:0] != 2'b00)) begin
                    nextState = IDLE;
                    misalign  = 1'b1;
                end
`endif
            end
            ISSUE: begin
                if (mem_ready) begin
                    if (weQ) begin
                        opComplete = 1'b1;
                        nextState  = IDLE;
                    end else begin
                        nextState = WAIT_RD;
                    end
                end
            end
            WAIT_RD: begin
                if (mem_rvalid) begin
                    opComplete = 1'b1;
                    nextState  = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Latch the granted request so memory sees stable signals until accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ownerQ <= OWN_CORE;
            weQ    <= 1'b0;
            addrQ  <= '0;
            wdataQ <= '0;
        end else if (state == IDLE && nextState == ISSUE) begin
            if (gntAux) begin
                ownerQ <= OWN_AUX;
                weQ    <= aux_we;
                addrQ  <= aux_addr;
                wdataQ <= aux_wdata;
            end else begin
                ownerQ <= OWN_CORE;
                weQ    <= core_we;
                addrQ  <= core_addr;
                wdataQ <= core_wdata;
            end
        end
    end

    // Registered done pulses and per-owner read data capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            coreDoneQ  <= 1'b0;
            auxDoneQ   <= 1'b0;
            coreRdataQ <= '0;
            auxRdataQ  <= '0;
        end else begin
            coreDoneQ <= (opComplete && ownerQ == OWN_CORE) || misalign;
            auxDoneQ  <= opComplete && ownerQ == OWN_AUX;
            if (opComplete && state == WAIT_RD) begin
                if (ownerQ == OWN_AUX) begin
                    auxRdataQ <= mem_rdata;
                end else begin
                    coreRdataQ <= mem_rdata;
                end
            end
        end
    end

`ifdef MISALIGN_CHECK_EN
    logic coreErrQ;

    // Error flag pulses alongside the core done for a rejected access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            coreErrQ <= 1'b0;
        end else begin
            coreErrQ <= misalign;
        end
    end

    assign core_err = coreErrQ;
`endif

    assign mem_req    = (state == ISSUE);
    assign mem_we     = (state == ISSUE) && weQ;
    assign mem_addr   = addrQ;
    assign mem_wdata  = wdataQ;
    assign core_done  = coreDoneQ;
    assign aux_done   = auxDoneQ;
    assign core_rdata = coreRdataQ;
    assign aux_rdata  = auxRdataQ;
    assign core_stall = core_req && !coreDoneQ;

endmodule

// File: tb/tb_dmem_arbiter_ctrl.sv
// Directed self-checking bench for dmem_arbiter_ctrl.
// MISALIGN_CHECK_EN, when defined, also exercises core_err.
module tb_dmem_arbiter_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, core_we;
    logic [31:0] core_addr, core_wdata;
    logic        core_stall, core_done;
    logic [31:0] core_rdata;
    logic        aux_req, aux_we;
    logic [31:0] aux_addr, aux_wdata;
    logic        aux_done;
    logic [31:0] aux_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready, mem_rvalid;
    logic [31:0] mem_rdata;
`ifdef MISALIGN_CHECK_EN
    logic        core_err;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_arbiter_ctrl #(
        .ADDR_W(32),
        .DATA_W(32),
        .STARVE_MAX(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_stall (core_stall),
        .core_done  (core_done),
        .core_rdata (core_rdata),
`ifdef MISALIGN_CHECK_EN
        .core_err   (core_err),
`endif
        .aux_req    (aux_req),
        .aux_we     (aux_we),
        .aux_addr   (aux_addr),
        .aux_wdata  (aux_wdata),
        .aux_done   (aux_done),
        .aux_rdata  (aux_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    // Move to the start of the next cycle (just after the rising edge).
    task automatic nextCyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
        aux_req = 0; aux_we = 0; aux_addr = '0; aux_wdata = '0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
        #12;
        checks++;
        if ({mem_req, mem_we, core_done, aux_done, core_stall} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 00000", {mem_req, mem_we, core_done, aux_done, core_stall});
        end
        checks++;
        if ({mem_addr, mem_wdata, core_rdata, aux_rdata} !== 128'd0) begin
            errors++; $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, core_rdata, aux_rdata});
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_core_store();
        nextCyc();                                    // cycle 0
        core_req = 1; core_we = 1; core_addr = 32'h40; core_wdata = 32'hDEADBEEF; mem_ready = 1;
        @(negedge clk);
        checks++;
        if ({core_stall, mem_req} !== 2'b10) begin
            errors++; $display("FAIL st_c0: stall,req got %b expected 10", {core_stall, mem_req});
        end
        nextCyc(); @(negedge clk);                    // cycle 1
        checks++;
        if ({mem_req, mem_we, core_stall, core_done} !== 4'b1110 || mem_addr !== 32'h40 || mem_wdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL st_c1: req,we,stall,done=%b addr=%h wdata=%h expected 1110 40 deadbeef", {mem_req, mem_we, core_stall, core_done}, mem_addr, mem_wdata);
        end
        nextCyc(); @(negedge clk);                    // cycle 2
        checks++;
        if ({core_done, core_stall, mem_req} !== 3'b100) begin
            errors++; $display("FAIL st_c2: done,stall,req got %b expected 100", {core_done, core_stall, mem_req});
        end
        nextCyc();                                    // cycle 3: request released
        core_req = 0;
        @(negedge clk);
        checks++;
        if ({mem_req, core_done} !== 2'b00) begin
            errors++; $display("FAIL st_noreissue: req,done got %b expected 00", {mem_req, core_done});
        end
        mem_ready = 0;
    endtask

    task automatic test_core_load();
        for (int k = 0; k <= 8; k++) begin
            nextCyc();
            mem_ready = (k == 4);
            mem_rvalid = (k >= 1 && k <= 3) || (k == 6);
            mem_rdata = (k == 6) ? 32'hDEADBEEF : 32'h12345678;
            if (k == 0) begin core_req = 1; core_we = 0; core_addr = 32'h40; end
            if (k == 8) core_req = 0;
            @(negedge clk);
            if (k >= 1 && k <= 4) begin
                checks++;
                if ({mem_req, mem_we, core_done} !== 3'b100 || mem_addr !== 32'h40) begin
                    errors++; $display("FAIL ld_issue_c%0d: req,we,done=%b addr=%h expected 100 40", k, {mem_req, mem_we, core_done}, mem_addr);
                end
            end
            if (k == 5 || k == 6) begin
                checks++;
                if ({mem_req, core_done} !== 2'b00) begin
                    errors++; $display("FAIL ld_wait_c%0d: req,done got %b expected 00", k, {mem_req, core_done});
                end
            end
            if (k == 7) begin
                checks++;
                if (core_done !== 1'b1 || core_rdata !== 32'hDEADBEEF || core_stall !== 1'b0) begin
                    errors++; $display("FAIL ld_done: done=%b rdata=%h stall=%b expected 1 deadbeef 0", core_done, core_rdata, core_stall);
                end
                core_req = 0;
            end
            if (k == 8) begin
                checks++;
                if (core_done !== 1'b0 || core_rdata !== 32'hDEADBEEF || mem_req !== 1'b0) begin
                    errors++; $display("FAIL ld_after: done=%b rdata=%h req=%b expected 0 deadbeef 0", core_done, core_rdata, mem_req);
                end
            end
        end
        mem_rvalid = 0; mem_ready = 0;
    endtask

    task automatic test_starvation();
        int          issCyc[$];
        logic [31:0] issAddr[$];
        int          coreDones = 0;
        int          auxDones = 0;
        int          auxDoneCyc = -1;
        for (int k = 0; k < 20; k++) begin
            nextCyc();
            if (k == 0) begin
                mem_ready = 1;
                core_req = 1; core_we = 1; core_addr = 32'h100; core_wdata = 32'h1;
                aux_req = 1; aux_we = 1; aux_addr = 32'h200; aux_wdata = 32'h2;
            end
            @(negedge clk);
            if (mem_req) begin issCyc.push_back(k); issAddr.push_back(mem_addr); end
            if (core_done) coreDones++;
            if (aux_done) begin auxDones++; auxDoneCyc = k; aux_req = 0; end
        end
        nextCyc(); core_req = 0;
        repeat (3) nextCyc();
        mem_ready = 0;
        checks++;
        if (issCyc.size() !== 7) begin
            errors++; $display("FAIL stv_count: issues got %0d expected 7", issCyc.size());
        end else begin
            checks++;
            if (issCyc[0] != 1 || issCyc[1] != 4 || issCyc[2] != 7 || issAddr[0] !== 32'h100 || issAddr[1] !== 32'h100 || issAddr[2] !== 32'h100) begin
                errors++; $display("FAIL stv_core_first: cycles %0d,%0d,%0d addrs %h,%h,%h expected 1,4,7 all 100", issCyc[0], issCyc[1], issCyc[2], issAddr[0], issAddr[1], issAddr[2]);
            end
            checks++;
            if (issCyc[3] != 10 || issAddr[3] !== 32'h200) begin
                errors++; $display("FAIL stv_aux_forced: cycle %0d addr %h expected 10 200", issCyc[3], issAddr[3]);
            end
            checks++;
            if (issCyc[4] != 13 || issAddr[4] !== 32'h100) begin
                errors++; $display("FAIL stv_core_resume: cycle %0d addr %h expected 13 100", issCyc[4], issAddr[4]);
            end
        end
        checks++;
        if (coreDones != 5 || auxDones != 1 || auxDoneCyc != 11) begin
            errors++; $display("FAIL stv_dones: core=%0d aux=%0d auxCyc=%0d expected 5 1 11", coreDones, auxDones, auxDoneCyc);
        end
    endtask

    task automatic test_flush_then_aux();
        for (int k = 0; k <= 8; k++) begin
            nextCyc();
            mem_rvalid = (k == 3) || (k == 7);
            mem_rdata = (k == 3) ? 32'hCAFEF00D : 32'h5A5A5A5A;
            if (k == 0) begin
                mem_ready = 1;
                core_req = 1; core_we = 0; core_addr = 32'h80;
                aux_req = 1; aux_we = 0; aux_addr = 32'h300;
            end
            if (k == 2) core_req = 0;
            @(negedge clk);
            case (k)
                1: begin
                    checks++;
                    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h80) begin
                        errors++; $display("FAIL fl_core_issue: req=%b we=%b addr=%h expected 1 0 80", mem_req, mem_we, mem_addr);
                    end
                end
                4: begin
                    checks++;
                    if (core_done !== 1'b1 || core_rdata !== 32'hCAFEF00D || aux_done !== 1'b0) begin
                        errors++; $display("FAIL fl_core_done: done=%b rdata=%h auxdone=%b expected 1 cafef00d 0", core_done, core_rdata, aux_done);
                    end
                end
                5: begin
                    checks++;
                    if (mem_req !== 1'b0) begin
                        errors++; $display("FAIL fl_gap: req got %b expected 0", mem_req);
                    end
                end
                6: begin
                    checks++;
                    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h300) begin
                        errors++; $display("FAIL fl_aux_issue: req=%b we=%b addr=%h expected 1 0 300", mem_req, mem_we, mem_addr);
                    end
                end
                8: begin
                    checks++;
                    if (aux_done !== 1'b1 || aux_rdata !== 32'h5A5A5A5A || core_done !== 1'b0 || core_rdata !== 32'hCAFEF00D) begin
                        errors++; $display("FAIL fl_aux_done: done=%b rdata=%h coredone=%b corerdata=%h expected 1 5a5a5a5a 0 cafef00d", aux_done, aux_rdata, core_done, core_rdata);
                    end
                    aux_req = 0;
                end
                default: ;
            endcase
        end
        mem_ready = 0; mem_rvalid = 0;
    endtask

`ifdef MISALIGN_CHECK_EN
    task automatic test_misalign();
        nextCyc();
        mem_ready = 1;
        core_req = 1; core_we = 0; core_addr = 32'h42;
        @(negedge clk);
        nextCyc(); @(negedge clk);
        checks++;
        if ({mem_req, core_err, core_done} !== 3'b011 || core_rdata !== 32'hCAFEF00D) begin
            errors++; $display("FAIL mis_c1: req,err,done=%b rdata=%h expected 011 cafef00d", {mem_req, core_err, core_done}, core_rdata);
        end
        nextCyc(); core_req = 0;
        @(negedge clk);
        checks++;
        if ({mem_req, core_err, core_done} !== 3'b000) begin
            errors++; $display("FAIL mis_c2: req,err,done=%b expected 000", {mem_req, core_err, core_done});
        end
        mem_ready = 0;
    endtask
`endif

    task automatic test_reset_mid_txn();
        nextCyc();
        mem_ready = 0;
        aux_req = 1; aux_we = 1; aux_addr = 32'h44; aux_wdata = 32'h77;
        @(negedge clk);
        nextCyc();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h44) begin
            errors++; $display("FAIL rm_issue: req=%b addr=%h expected 1 44", mem_req, mem_addr);
        end
        #1 rst = 1'b0;
        #1;
        aux_req = 0;
        checks++;
        if ({mem_req, mem_we, core_done, aux_done} !== 4'b0 || {mem_addr, mem_wdata, core_rdata, aux_rdata} !== 128'd0) begin
            errors++; $display("FAIL rm_async: ctrl=%b data=%h expected 0", {mem_req, mem_we, core_done, aux_done}, {mem_addr, mem_wdata, core_rdata, aux_rdata});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            mem_ready = 1;
            nextCyc(); @(negedge clk);
            checks++;
            if ({mem_req, aux_done, core_done} !== 3'b000) begin
                errors++; $display("FAIL rm_after_c%0d: req,auxdone,coredone=%b expected 000", k, {mem_req, aux_done, core_done});
            end
        end
        mem_ready = 0;
    endtask

    initial begin
        test_reset();
        test_core_store();
        test_core_load();
        test_starvation();
        test_flush_then_aux();
`ifdef MISALIGN_CHECK_EN
        test_misalign();
`endif
        test_reset_mid_txn();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
